// File: rtl/uart.sv
// Full-duplex UART with two selectable baud rates, 8N1 by default.
// Define UART_PARITY_EN to insert/check an even parity bit after D7 (11-bit frame).
module uart #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD_0   = 115200,
    parameter int unsigned BAUD_1   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic [7:0] tx_data,
    input  logic       load,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] rx_data
);
    localparam int unsigned DIV0    = (CLK_FREQ + BAUD_0 / 2) / BAUD_0;
    localparam int unsigned DIV1    = (CLK_FREQ + BAUD_1 / 2) / BAUD_1;
    localparam int unsigned DIV_MAX = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int unsigned CW      = $clog2(DIV_MAX);

    // Divisors are stored as terminal counts (DIV-1, DIV/2-1).
    localparam logic [CW-1:0] DIV0_M1  = CW'(DIV0 - 1);
    localparam logic [CW-1:0] DIV1_M1  = CW'(DIV1 - 1);
    localparam logic [CW-1:0] HALF0_M1 = CW'(DIV0 / 2 - 1);
    localparam logic [CW-1:0] HALF1_M1 = CW'(DIV1 / 2 - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWait} rx_state_e;
`else
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;
`endif

    logic [CW-1:0] div_sel, half_sel;
    assign div_sel  = sel ? DIV1_M1 : DIV0_M1;
    assign half_sel = sel ? HALF1_M1 : HALF0_M1;

    // ---------------- transmitter ----------------
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [CW-1:0] tx_div_q, tx_div_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;
    logic          tx_tick, tx_start;
`ifdef UART_PARITY_EN
    logic          tx_par_q, tx_par_d;
`endif

    assign tx_tick = (tx_cnt_q == tx_div_q);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_start   = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tx_state_q != TxIdle) begin
            tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
        end
        case (tx_state_q)
            TxIdle:  tx_start = load;
            TxStart: if (tx_tick) tx_state_d = TxData;
            TxData: begin
                if (tx_tick) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TxParity;
`else
                        tx_state_d = TxStop;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            TxParity: if (tx_tick) tx_state_d = TxStop;
`endif
            TxStop: begin
                if (tx_tick) begin
                    tx_state_d = TxIdle;
                    // Load still high at end of stop: chain the next frame with no gap.
                    tx_start   = load;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
        if (tx_start) begin
            tx_state_d = TxStart;
            tx_shift_d = tx_data;
            tx_div_d   = div_sel;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
`ifdef UART_PARITY_EN
            tx_par_d   = ^tx_data;
`endif
        end

        txd_d = 1'b1;
        case (tx_state_d)
            TxStart:  txd_d = 1'b0;
            TxData:   txd_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            TxParity: txd_d = tx_par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [CW-1:0] rx_div_q, rx_div_d;
    logic [CW-1:0] rx_half_q, rx_half_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rxd_meta_q, rxd_sync_q;
    logic          rx_tick, rx_ok;
`ifdef UART_PARITY_EN
    logic          rx_perr_q, rx_perr_d;
    assign rx_ok = rxd_sync_q && !rx_perr_q;
`else
    assign rx_ok = rxd_sync_q;
`endif

    assign rx_tick = (rx_cnt_q == rx_div_q);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_tick ? '0 : rx_cnt_q + CW'(1);
        rx_div_d   = rx_div_q;
        rx_half_d  = rx_half_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
`ifdef UART_PARITY_EN
        rx_perr_d  = rx_perr_q;
`endif
        case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (!rxd_sync_q) begin
                    rx_state_d = RxStart;
                    rx_div_d   = div_sel;
                    rx_half_d  = half_sel;
`ifdef UART_PARITY_EN
                    rx_perr_d  = 1'b0;
`endif
                end
            end
            RxStart: begin
                rx_cnt_d = rx_cnt_q + CW'(1);
                // Mid-start re-sample: a high level here means the edge was a glitch.
                if (rx_cnt_q == rx_half_q) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_tick) begin
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RxParity;
`else
                        rx_state_d = RxStop;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            RxParity: begin
                if (rx_tick) begin
                    rx_perr_d  = rxd_sync_q ^ (^rx_shift_q);
                    rx_state_d = RxStop;
                end
            end
`endif
            RxStop: begin
                if (rx_tick) begin
                    if (rx_ok) begin
                        rx_data_d  = rx_shift_q;
                        rx_state_d = RxIdle;
                    end else begin
                        rx_state_d = RxWait;
                    end
                end
            end
            RxWait: begin
                rx_cnt_d = '0;
                if (rxd_sync_q) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_half_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= 8'h00;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_half_q  <= rx_half_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    assign txd     = txd_q;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: instance a transmits into peer b; a's receiver is driven directly.
// Clock is scaled to 10 MHz so that divisors are 87 (sel=0) and 1042 (sel=1).
module tb_uart;
    localparam int unsigned CLK_FREQ = 10_000_000;
    localparam int DIV0 = 87;   // round(10e6 / 115200)
    localparam int DIV1 = 1042; // round(10e6 / 9600)

    logic       clk = 1'b0;
    logic       rst, sel_a, sel_b, load_a, rxd_drv;
    logic [7:0] tx_data_a, rx_data_a, rx_data_b;
    logic       txd_a, txd_b;
    int         vectors = 0;
    int         errors  = 0;

    always #5 clk = ~clk;

    uart #(.CLK_FREQ(CLK_FREQ), .BAUD_0(115200), .BAUD_1(9600)) u_a (
        .clk(clk), .rst(rst), .sel(sel_a), .tx_data(tx_data_a), .load(load_a),
        .rxd(rxd_drv), .txd(txd_a), .rx_data(rx_data_a)
    );

    uart #(.CLK_FREQ(CLK_FREQ), .BAUD_0(115200), .BAUD_1(9600)) u_b (
        .clk(clk), .rst(rst), .sel(sel_b), .tx_data(8'h00), .load(1'b0),
        .rxd(txd_a), .txd(txd_b), .rx_data(rx_data_b)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called one sample after the edge on which txd_a goes low; walks the whole frame.
    task automatic check_frame(input logic [7:0] b, input int div, input string name,
                               input bit mid, input logic [7:0] mid_data);
        logic [10:0] fr;
        int          nb;
        bit          bad;
        logic        got;
`ifdef UART_PARITY_EN
        nb = 11;
        fr = {1'b1, ^b, b, 1'b0};
`else
        nb = 10;
        fr = {1'b0, 1'b1, b, 1'b0};
`endif
        for (int i = 0; i < nb; i++) begin
            bad = 1'b0;
            got = fr[i];
            for (int j = 0; j < div; j++) begin
                if (txd_a !== fr[i]) begin
                    bad = 1'b1;
                    got = txd_a;
                end
                if (mid && i == 4 && j == 0) tx_data_a = mid_data;
                step(1);
            end
            vectors++;
            if (bad) begin
                errors++;
                $display("FAIL %s bit%0d: txd=%b expected %b", name, i, got, fr[i]);
            end
        end
    endtask

    task automatic send_raw(input logic [7:0] b, input logic stop);
        logic [10:0] fr;
        int          nb;
`ifdef UART_PARITY_EN
        nb = 11;
        fr = {stop, ^b, b, 1'b0};
`else
        nb = 10;
        fr = {1'b1, stop, b, 1'b0};
`endif
        for (int i = 0; i < nb; i++) begin
            rxd_drv = fr[i];
            step(DIV0);
        end
        rxd_drv = 1'b1;
        step(DIV0);
    endtask

    task automatic test_reset();
        bit bad;
        rst = 1'b1; load_a = 1'b0; tx_data_a = 8'h00;
        sel_a = 1'b0; sel_b = 1'b0; rxd_drv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            vectors++;
            if (txd_a !== 1'b1 || txd_b !== 1'b1 || rx_data_a !== 8'h00 || rx_data_b !== 8'h00) begin
                errors++;
                $display("FAIL reset_cyc%0d: txd_a=%b txd_b=%b rx_a=%h rx_b=%h expected 1 1 00 00",
                         i, txd_a, txd_b, rx_data_a, rx_data_b);
            end
        end
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (txd_a !== 1'b1 || txd_b !== 1'b1 || rx_data_a !== 8'h00 || rx_data_b !== 8'h00)
                bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            errors++;
            $display("FAIL reset_idle: txd_a=%b rx_a=%h rx_b=%h expected 1 00 00",
                     txd_a, rx_data_a, rx_data_b);
        end
    endtask

    task automatic test_loopback();
        tx_data_a = 8'h92; load_a = 1'b1;
        step(1);
        load_a = 1'b0;
        check_frame(8'h92, DIV0, "loop_92", 1'b0, 8'h00);
        step(4);
        vectors++;
        if (rx_data_b !== 8'h92) begin
            errors++;
            $display("FAIL loop_rx: rx_b=%h expected 92", rx_data_b);
        end
    endtask

    task automatic test_back_to_back();
        tx_data_a = 8'h92; load_a = 1'b1;
        step(1);
        check_frame(8'h92, DIV0, "b2b_first", 1'b1, 8'hA4);
        load_a = 1'b0;
        vectors++;
        if (rx_data_b !== 8'h92) begin
            errors++;
            $display("FAIL b2b_rx_first: rx_b=%h expected 92", rx_data_b);
        end
        check_frame(8'hA4, DIV0, "b2b_second", 1'b0, 8'h00);
        step(4);
        vectors++;
        if (rx_data_b !== 8'hA4 || txd_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rx_second: rx_b=%h txd=%b expected A4 1", rx_data_b, txd_a);
        end
    endtask

    task automatic test_sel1();
        sel_a = 1'b1; sel_b = 1'b1;
        tx_data_a = 8'h5A; load_a = 1'b1;
        step(1);
        load_a = 1'b0;
        sel_a  = 1'b0;   // must not affect the frame already started
        check_frame(8'h5A, DIV1, "sel1_5a", 1'b0, 8'h00);
        step(4);
        vectors++;
        if (rx_data_b !== 8'h5A) begin
            errors++;
            $display("FAIL sel1_rx: rx_b=%h expected 5A", rx_data_b);
        end
        sel_b = 1'b0;
    endtask

    task automatic test_framing();
        send_raw(8'h81, 1'b1);
        vectors++;
        if (rx_data_a !== 8'h81) begin
            errors++;
            $display("FAIL frame_good_81: rx_a=%h expected 81", rx_data_a);
        end
        send_raw(8'h3C, 1'b0);
        vectors++;
        if (rx_data_a !== 8'h81) begin
            errors++;
            $display("FAIL frame_bad_stop: rx_a=%h expected 81", rx_data_a);
        end
        send_raw(8'hC3, 1'b1);
        vectors++;
        if (rx_data_a !== 8'hC3) begin
            errors++;
            $display("FAIL frame_after_err: rx_a=%h expected C3", rx_data_a);
        end
    endtask

    task automatic test_glitch();
        rxd_drv = 1'b0;
        step(DIV0 / 4);
        rxd_drv = 1'b1;
        step(2 * DIV0);
        vectors++;
        if (rx_data_a !== 8'hC3) begin
            errors++;
            $display("FAIL glitch_ignored: rx_a=%h expected C3", rx_data_a);
        end
        send_raw(8'h17, 1'b1);
        vectors++;
        if (rx_data_a !== 8'h17) begin
            errors++;
            $display("FAIL glitch_recover: rx_a=%h expected 17", rx_data_a);
        end
    endtask

    task automatic test_rst_mid_tx();
        bit bad;
        tx_data_a = 8'h00; load_a = 1'b1;
        step(1);
        load_a = 1'b0;
        step(3 * DIV0);
        vectors++;
        if (txd_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre: txd=%b expected 0", txd_a);
        end
        rst = 1'b1;
        step(1);
        vectors++;
        if (txd_a !== 1'b1 || rx_data_a !== 8'h00 || rx_data_b !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid: txd=%b rx_a=%h rx_b=%h expected 1 00 00",
                     txd_a, rx_data_a, rx_data_b);
        end
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 12 * DIV0; i++) begin
            step(1);
            if (txd_a !== 1'b1 || rx_data_b !== 8'h00) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            errors++;
            $display("FAIL rst_after: txd=%b rx_b=%h expected 1 00", txd_a, rx_data_b);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_sel1();
        test_framing();
        test_glitch();
        test_rst_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
